// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper and its BCD display converter.
package score_pkg;

  localparam int unsigned BIN_W         = 14;
  localparam int unsigned SHIFT_CYCLES  = 14;
  localparam int unsigned SAT_VALUE_DEF = 9999;
  localparam int unsigned CNT_W         = $clog2(SHIFT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_e;

  // Saturate a 32-bit score to the display limit and narrow it to the converter width.
  function automatic logic [BIN_W-1:0] clamp_sat(input logic [31:0] value,
                                                 input logic [31:0] sat);
    return (value > sat) ? BIN_W'(sat) : BIN_W'(value);
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: one LOAD, SHIFT_CYCLES shifts, one DONE per conversion.
module bin2bcd
  import score_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  conv_state_e           state_q, state_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   bcd_adj;

  always_comb begin
    bcd_adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        bin_d     = bin_in;
        scratch_d = '0;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        {scratch_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d              = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SHIFT_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = start ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == LOAD) || (state_q == SHIFT);
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/score_keeper.sv
// High-score tracking, restart pulse generation and free-running BCD display refresh.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SAT_VALUE = SAT_VALUE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           points,
  input  logic                  terminated,
  input  logic                  restart,
  input  logic                  show_hs,
  output logic                  hs_rst,
  output logic [31:0]           high_score,
  output logic                  new_record,
  output logic [4*DIGITS-1:0]   bcd_digits,
  output logic                  bcd_valid
);

  logic         term_q, term_d;
  logic         term_prev_q, term_prev_d;
  logic [31:0]  high_score_q, high_score_d;
  logic         new_record_q, new_record_d;
  logic         hs_rst_q, hs_rst_d;
  logic         term_rise;
  logic         record;
  logic [31:0]  conv_src;
  logic [BIN_W-1:0] conv_bin;
  logic         conv_busy;
  logic         conv_start;

  always_comb begin
    term_d       = terminated;
    term_prev_d  = term_q;
    term_rise    = term_q & ~term_prev_q;
    record       = term_rise && (points > high_score_q);
    high_score_d = high_score_q;
    new_record_d = new_record_q;
    hs_rst_d     = restart;
    // A record in the same cycle as restart wins: the flag must survive the clear.
    if (record) begin
      high_score_d = points;
      new_record_d = 1'b1;
    end else if (restart) begin
      new_record_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_q       <= 1'b0;
      term_prev_q  <= 1'b0;
      high_score_q <= '0;
      new_record_q <= 1'b0;
      hs_rst_q     <= 1'b0;
    end else begin
      term_q       <= term_d;
      term_prev_q  <= term_prev_d;
      high_score_q <= high_score_d;
      new_record_q <= new_record_d;
      hs_rst_q     <= hs_rst_d;
    end
  end

  always_comb begin
    conv_src   = show_hs ? high_score_q : points;
    conv_bin   = clamp_sat(conv_src, 32'(SAT_VALUE));
    conv_start = ~conv_busy;
  end

  bin2bcd #(
    .DIGITS(DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (conv_start),
    .bin_in  (conv_bin),
    .busy    (conv_busy),
    .done    (bcd_valid),
    .bcd_out (bcd_digits)
  );

  assign hs_rst     = hs_rst_q;
  assign high_score = high_score_q;
  assign new_record = new_record_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed vectors plus a randomized run against a reference model.
module tb_score_keeper;

  localparam int RND_N = 1600;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] points;
  logic        terminated, restart, show_hs;
  logic        hs_rst, new_record, bcd_valid;
  logic [31:0] high_score;
  logic [15:0] bcd_digits;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] pts;
    logic        show;
    logic [15:0] bcd;
  } vec_t;

  vec_t tbl[9];

  logic [31:0] p_h  [RND_N+1];
  logic        t_h  [RND_N+1];
  logic        r_h  [RND_N+1];
  logic        s_h  [RND_N+1];
  logic [31:0] hsb_h[RND_N+1];

  score_keeper #(.DIGITS(4), .SAT_VALUE(9999)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .points     (points),
    .terminated (terminated),
    .restart    (restart),
    .show_hs    (show_hs),
    .hs_rst     (hs_rst),
    .high_score (high_score),
    .new_record (new_record),
    .bcd_digits (bcd_digits),
    .bcd_valid  (bcd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input logic [31:0] v);
    logic [15:0] r;
    int unsigned x;
    x = (v > 32'd9999) ? 9999 : int'(v);
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_high_score", high_score, 0);
    chk("rst_new_record", new_record, 0);
    chk("rst_hs_rst",     hs_rst, 0);
    chk("rst_bcd_digits", bcd_digits, 0);
    chk("rst_bcd_valid",  bcd_valid, 0);
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Called right after reset release: first strobe must land on the 17th edge.
  task automatic check_first_valid(input string tag, input logic [15:0] exp);
    bit early;
    early = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bcd_valid !== 1'b0) early = 1'b1;
    end
    chk({tag, "_early_valid"}, early, 0);
    tick();
    chk({tag, "_first_valid"}, bcd_valid, 1);
    chk({tag, "_first_bcd"}, bcd_digits, exp);
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bcd_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_valid_seen"}, seen, 1);
  endtask

  task automatic conv_check(input string name, input logic [31:0] p, input logic s,
                            input logic [15:0] exp);
    points  = p;
    show_hs = s;
    wait_valid(name);
    wait_valid(name);
    chk(name, bcd_digits, exp);
  endtask

  initial begin
    tbl[0] = '{"tbl_zero",    32'd0,      1'b0, 16'h0000};
    tbl[1] = '{"tbl_1234",    32'd1234,   1'b0, 16'h1234};
    tbl[2] = '{"tbl_9999",    32'd9999,   1'b0, 16'h9999};
    tbl[3] = '{"tbl_10000",   32'd10000,  1'b0, 16'h9999};
    tbl[4] = '{"tbl_123456",  32'd123456, 1'b0, 16'h9999};
    tbl[5] = '{"tbl_7",       32'd7,      1'b0, 16'h0007};
    tbl[6] = '{"tbl_5555",    32'd5555,   1'b0, 16'h5555};
    tbl[7] = '{"tbl_1000",    32'd1000,   1'b0, 16'h1000};
    tbl[8] = '{"tbl_hs_zero", 32'd4321,   1'b1, 16'h0000};

    points = '0; terminated = 1'b0; restart = 1'b0; show_hs = 1'b0;
    #2;
    apply_reset();
    check_first_valid("boot", 16'h0000);

    begin
      bit early;
      early = 1'b0;
      for (int k = 0; k < 15; k++) begin
        tick();
        if (bcd_valid !== 1'b0) early = 1'b1;
      end
      chk("period_early_valid", early, 0);
      tick();
      chk("period_valid", bcd_valid, 1);
    end

    for (int i = 0; i < 9; i++) conv_check(tbl[i].name, tbl[i].pts, tbl[i].show, tbl[i].bcd);

    // Reset in the middle of a conversion aborts it.
    show_hs = 1'b0;
    points  = 32'd4321;
    repeat (5) tick();
    apply_reset();
    check_first_valid("midrst", 16'h4321);

    // First game ends with 1234.
    points = 32'd1234; terminated = 1'b0;
    tick();
    terminated = 1'b1;
    tick();
    chk("rec_not_yet", high_score, 0);
    tick();
    chk("rec_high_score", high_score, 1234);
    chk("rec_new_record", new_record, 1);
    conv_check("rec_hs_display", 32'd1234, 1'b1, 16'h1234);

    // Restart pulse.
    show_hs = 1'b0;
    chk("rs_idle_hs_rst", hs_rst, 0);
    restart = 1'b1; terminated = 1'b0;
    tick();
    chk("rs_hs_rst_high", hs_rst, 1);
    chk("rs_new_record_clr", new_record, 0);
    restart = 1'b0;
    tick();
    chk("rs_hs_rst_low", hs_rst, 0);
    tick();
    chk("rs_hs_rst_stays_low", hs_rst, 0);

    // Second game worse than the record.
    points = 32'd1000; terminated = 1'b1;
    tick(); tick();
    chk("low_high_score", high_score, 1234);
    chk("low_new_record", new_record, 0);

    // Held terminated must not re-trigger.
    points = 32'd5000;
    repeat (4) tick();
    chk("held_term_high_score", high_score, 1234);

    conv_check("sat_live", 32'd123456, 1'b0, 16'h9999);
    terminated = 1'b0;
    tick();
    terminated = 1'b1;
    tick(); tick();
    chk("big_high_score", high_score, 123456);
    chk("big_new_record", new_record, 1);
    conv_check("sat_hs", 32'd123456, 1'b1, 16'h9999);

    // Tie with the record changes nothing.
    restart = 1'b1; terminated = 1'b0;
    tick();
    restart = 1'b0;
    tick();
    terminated = 1'b1;
    tick(); tick();
    chk("tie_high_score", high_score, 123456);
    chk("tie_new_record", new_record, 0);

    // Game end coinciding with restart.
    terminated = 1'b0; show_hs = 1'b0;
    apply_reset();
    points = 32'd100; terminated = 1'b1;
    tick(); tick();
    chk("sim_pre_high_score", high_score, 100);
    terminated = 1'b0;
    tick();
    points = 32'd500; terminated = 1'b1;
    tick();
    restart = 1'b1;
    tick();
    chk("sim_high_score", high_score, 500);
    chk("sim_new_record", new_record, 1);
    chk("sim_hs_rst_high", hs_rst, 1);
    restart = 1'b0; points = 32'd0;
    tick();
    chk("sim_hs_rst_low", hs_rst, 0);
    chk("sim_new_record_kept", new_record, 1);
    chk("sim_high_score_kept", high_score, 500);

    // Randomized run against the reference model.
    terminated = 1'b0; restart = 1'b0; show_hs = 1'b0;
    apply_reset();
    begin
      logic [31:0] hs_m;
      logic        nr_m;
      logic        rise;
      logic        exp_valid;
      logic [31:0] src;
      hs_m = '0;
      nr_m = 1'b0;
      p_h[0] = '0; t_h[0] = 1'b0; r_h[0] = 1'b0; s_h[0] = 1'b0; hsb_h[0] = '0;
      for (int j = 1; j <= RND_N; j++) begin
        p_h[j] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12000));
        t_h[j] = ($urandom_range(0, 5) == 0) ? ~t_h[j-1] : t_h[j-1];
        r_h[j] = r_h[j-1] ? 1'b0 : ($urandom_range(0, 11) == 0);
        s_h[j] = ($urandom_range(0, 9) == 0) ? ~s_h[j-1] : s_h[j-1];
        points = p_h[j]; terminated = t_h[j]; restart = r_h[j]; show_hs = s_h[j];
        tick();
        rise = (j >= 2) && t_h[j-1] && !t_h[j-2];
        hsb_h[j] = hs_m;
        if (rise && (p_h[j] > hs_m)) begin
          hs_m = p_h[j];
          nr_m = 1'b1;
        end else if (r_h[j]) begin
          nr_m = 1'b0;
        end
        exp_valid = (j >= 17) && (((j - 17) % 16) == 0);
        chk("rnd_high_score", high_score, hs_m);
        chk("rnd_new_record", new_record, nr_m);
        chk("rnd_hs_rst", hs_rst, r_h[j]);
        chk("rnd_bcd_valid", bcd_valid, exp_valid);
        if (exp_valid) begin
          src = s_h[j-15] ? hsb_h[j-15] : p_h[j-15];
          chk("rnd_bcd_digits", bcd_digits, to_bcd(src));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
